ccff_chain_loader: RTL

Configuration-chain loader for a tile's configuration flip-flop chain (routing-mux memories plus IO-tile configuration bits). It accepts bitstream words over a valid/ready handshake and serializes them one bit per cycle onto `ccff_head`. It qualifies each shift with `config_enable` and counts bits so that exactly `CHAIN_LEN` shifts occur per load. It sits between the top-level programming interface and the `ccff_head` input of the first tile in the chain.

---
 rtl/ccff_loader_pkg.sv | 20 ++
 rtl/ccff_chain_loader_if.sv | 15 +
 rtl/ccff_serializer.sv | 44 ++++
 rtl/ccff_chain_loader.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared types and sizing helpers for the configuration-chain loader.
// Holds the loader state encoding, default geometry and the counter-width helper.
package ccff_loader_pkg;

    localparam int DEFAULT_CHAIN_LEN = 41;
    localparam int DEFAULT_WORD_W    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Width needed to count from 0 up to and including n.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Bitstream word handshake between the programming interface and the loader.
// The master drives words; the slave (loader) drives cfg_ready.
interface ccff_chain_loader_if
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W = DEFAULT_WORD_W
);
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_last;
    logic              cfg_ready;

    modport master (output cfg_data, cfg_valid, cfg_last, input cfg_ready);
    modport slave  (input cfg_data, cfg_valid, cfg_last, output cfg_ready);
endinterface

// File: rtl/ccff_serializer.sv
// Word register for the loader: captures a word, then hands out its bits LSB-first.
// next_bit is the bit that will be on ccff_head in the cycle after the current edge.
module ccff_serializer
    import ccff_loader_pkg::*;
#(
    parameter  int WORD_W = DEFAULT_WORD_W,
    localparam int BC_W   = cnt_width(WORD_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] data,
    input  logic [BC_W-1:0]   n_bits,
    output logic              next_bit,
    output logic              word_last
);

    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] shifted;
    logic [BC_W-1:0]   rem;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            shreg <= '0;
            rem   <= '0;
        end else if (load) begin
            shreg <= data;
            rem   <= n_bits;
        end else if (shift) begin
            shreg <= shifted;
            rem   <= rem - BC_W'(1);
        end
    end

    // On a capture the first bit comes straight from the bus; otherwise the one behind the LSB.
    always_comb begin
        shifted   = shreg >> 1;
        next_bit  = load ? data[0] : shifted[0];
        word_last = (rem == BC_W'(1));
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: FSM, chain bit counter, framing check and optional readback.
// Define CCFF_READBACK_EN to capture ccff_tail into rb_data/rb_valid while shifting.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = DEFAULT_CHAIN_LEN,
    parameter int WORD_W    = DEFAULT_WORD_W
) (
    input  logic                    prog_clk,
    input  logic                    pReset,
    input  logic                    start,
    ccff_chain_loader_if.slave      bus,
    output logic                    ccff_head,
    input  logic                    ccff_tail,
    output logic                    config_enable,
    output logic                    busy,
    output logic                    done,
    output logic                    err
`ifdef CCFF_READBACK_EN
    ,
    output logic [WORD_W-1:0]       rb_data,
    output logic                    rb_valid
`endif
);

    localparam int CNT_W = cnt_width(CHAIN_LEN);
    localparam int BC_W  = cnt_width(WORD_W);

    state_t           state, state_next;
    logic [CNT_W-1:0] bit_cnt;
    logic             last_q;
    logic             clear;
    logic             handshake;
    logic             set_err;
    logic             chain_full;
    logic             next_bit;
    logic             word_last;
    logic [BC_W-1:0]  n_bits;
    int               bits_left;

    assign bus.cfg_ready = (state == LOAD);
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
    assign handshake     = (state == LOAD) && bus.cfg_valid;
    assign chain_full    = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
    assign bits_left     = CHAIN_LEN - int'(bit_cnt);
    assign n_bits        = BC_W'((bits_left > WORD_W) ? WORD_W : bits_left);

    ccff_serializer #(.WORD_W(WORD_W)) u_serializer (
        .clk       (prog_clk),
        .rst       (pReset),
        .clear     (clear),
        .load      (handshake),
        .shift     (state == SHIFT),
        .data      (bus.cfg_data),
        .n_bits    (n_bits),
        .next_bit  (next_bit),
        .word_last (word_last)
    );

    // A word ends either at the chain end or, framed early by cfg_last, before it.
    always_comb begin
        state_next = state;
        clear      = 1'b0;
        set_err    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                    clear      = 1'b1;
                end
            end
            LOAD: begin
                if (bus.cfg_valid) state_next = SHIFT;
            end
            SHIFT: begin
                if (word_last) begin
                    if (chain_full) begin
                        state_next = DONE;
                        set_err    = !last_q;
                    end else if (last_q) begin
                        state_next = DONE;
                        set_err    = 1'b1;
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            last_q        <= 1'b0;
            err           <= 1'b0;
            ccff_head     <= 1'b0;
            config_enable <= 1'b0;
        end else begin
            state         <= state_next;
            config_enable <= (state_next == SHIFT);
            if (state_next == SHIFT) ccff_head <= next_bit;
            if (handshake) last_q <= bus.cfg_last;
            if (clear) begin
                bit_cnt <= '0;
                err     <= 1'b0;
            end else begin
                if (state == SHIFT) bit_cnt <= bit_cnt + CNT_W'(1);
                if (set_err) err <= 1'b1;
            end
        end
    end

`ifdef CCFF_READBACK_EN
    logic [WORD_W-1:0] rb_acc;
    logic [WORD_W-1:0] rb_word;
    logic [BC_W-1:0]   rb_cnt;

    always_comb begin
        rb_word = rb_acc;
        for (int i = 0; i < WORD_W; i++) begin
            if (i == int'(rb_cnt)) rb_word[i] = ccff_tail;
        end
    end

    // A partial final word leaves on the edge into DONE so rb_valid lines up with done.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            rb_acc   <= '0;
            rb_cnt   <= '0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            if (clear) begin
                rb_acc <= '0;
                rb_cnt <= '0;
            end else if (state == SHIFT) begin
                if (int'(rb_cnt) == WORD_W - 1 || state_next == DONE) begin
                    rb_data  <= rb_word;
                    rb_valid <= 1'b1;
                    rb_acc   <= '0;
                    rb_cnt   <= '0;
                end else begin
                    rb_acc <= rb_word;
                    rb_cnt <= rb_cnt + BC_W'(1);
                end
            end
        end
    end
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
`endif

endmodule
